pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Parametrised successor of the ID/EX-style pipeline register.
- Carries NUM_CH fields of WIDTH bits each, packed as {ch[NUM_CH-1],...,ch[0]}; default layout is pc, rs1_data, rs2_data, sext_imme.
- Adds a valid/ready handshake, a 2-entry skid buffer, distinct stall (hold) and flush (bubble) controls, and an occupancy output.
- Sits between any two pipeline stages; full throughput with registered in_ready, so no combinational ready path crosses the stage.

Parameters:
- WIDTH, 32, bits per channel
- NUM_CH, 4, number of channels carried
- BUBBLE_VAL, 0, WIDTH-bit value driven on every channel of out_data when the stage is empty, flushed or reset

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-low: rst=0 at a rising clk edge resets the block
- stall  in  1  downstream hold; while 1, the output entry is not consumed
- flush  in  1  kill everything held in the stage (branch/jump taken)
- in_valid  in  1  upstream offers in_data
- in_ready  out  1  stage can accept; registered
- in_data  in  NUM_CH*WIDTH  packed input fields
- out_valid  out  1  out_data holds a live entry
- out_ready  in  1  downstream consumes out_data
- out_data  out  NUM_CH*WIDTH  packed output fields; registered
- occupancy  out  2  live entries held (0..2)

Behaviour:
- Storage: main entry M (drives out_valid/out_data) and skid entry S. in_ready = !S_valid, registered. occupancy = M_valid + S_valid.
- accept = in_valid & in_ready. take = out_valid & out_ready & !stall.
- Priority per edge: reset > flush > normal operation.
- Reset (rst=0): M_valid=0, S_valid=0, in_ready=1, out_valid=0, out_data={NUM_CH{BUBBLE_VAL}}, occupancy=0. Mid-operation reset discards held entries; none leak out afterwards.
- Flush=1: same end state as reset. An input accepted in the flush cycle is discarded. Flush with stall=1 still clears.
- Normal operation, case M empty or take:
  - S valid: M<=S, S cleared; if accept, S<=in_data.
  - else if accept: M<=in_data.
  - else: M invalid, out_data<=bubble.
- Normal operation, case M full and no take:
  - M holds; out_data stable.
  - If accept: S<=in_data; in_ready falls next cycle.
- Latency: accepted word appears on out_data exactly 1 cycle later when M was empty or taken. Throughput 1 word/cycle when stall=0 and out_ready=1.
- Boundaries:
  - occupancy=2 implies in_ready=0; in_valid ignored.
  - Simultaneous take and accept at occupancy=2 is impossible, since in_ready=0. At occupancy 1 it keeps occupancy 1.
  - Order is strictly FIFO (S never overtakes M).
  - stall=1 with out_ready=1 is not a take.
  - out_data never changes while out_valid=1 and no take.

Optional Feature:
- Macro PIPE_STAGE_SKID_PERF_EN.
- Defined:
  - Adds outputs stall_cnt[31:0] and flush_cnt[31:0], reset to 0.
  - stall_cnt increments each cycle with out_valid & stall.
  - flush_cnt increments each cycle with flush=1 and occupancy!=0.
  - Both wrap at 2^32.
  - Neither counter is cleared by flush.
- Undefined: ports and counters absent; core behaviour identical.

Test Plan:
- Reset: rst=0 two cycles with in_valid=1, in_data=all 0xA5 → out_valid=0, out_data=0, in_ready=1, occupancy=0. Release; first accepted word appears on out_data next cycle.
- Streaming: stall=0, out_ready=1, feed pc=0x100,0x104,0x108 on consecutive cycles → same values on out_data cycles 1,2,3 later; occupancy stays 1; in_ready stays 1.
- Skid fill: M holds 0x200; stall=1 while 0x204 and then 0x208 are offered → 0x204 lands in S, in_ready=0, occupancy=2, 0x208 held upstream. Release stall → outputs 0x200,0x204,0x208 in order with no loss or duplication.
- Flush: occupancy=2, flush=1 together with in_valid=1 (0x300) → next cycle out_valid=0, out_data=0, occupancy=0, in_ready=1; 0x300 never appears.
- Parameters WIDTH=16, NUM_CH=2, BUBBLE_VAL=16'h0013 → idle out_data=32'h00130013; data {16'h1234,16'hBEEF} passes unchanged.
- PIPE_STAGE_SKID_PERF_EN defined: 5 stall cycles with out_valid=1, then 1 flush at occupancy=1 → stall_cnt=5, flush_cnt=1. A flush at occupancy=0 leaves flush_cnt=1.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Pipeline register with a valid/ready handshake, a 2-entry skid buffer, stall/flush controls and occupancy.
// Optional performance counters are enabled by defining PIPE_STAGE_SKID_PERF_EN.
module pipe_stage_skid #(
  parameter int unsigned          WIDTH      = 32,
  parameter int unsigned          NUM_CH     = 4,
  parameter logic [WIDTH-1:0]     BUBBLE_VAL = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_CH*WIDTH-1:0]   in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_CH*WIDTH-1:0]   out_data,
  output logic [1:0]                occupancy
`ifdef PIPE_STAGE_SKID_PERF_EN
  ,
  output logic [31:0]               stall_cnt,
  output logic [31:0]               flush_cnt
`endif
);

  localparam logic [NUM_CH*WIDTH-1:0] BUBBLE_WORD = {NUM_CH{BUBBLE_VAL}};

  logic                    m_valid_q, m_valid_d;
  logic [NUM_CH*WIDTH-1:0] m_data_q,  m_data_d;
  logic                    s_valid_q, s_valid_d;
  logic [NUM_CH*WIDTH-1:0] s_data_q,  s_data_d;
  logic                    in_ready_q, in_ready_d;

  logic accept;
  logic take;

  assign accept = in_valid & in_ready_q;
  assign take   = m_valid_q & out_ready & ~stall;

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    if (flush) begin
      m_valid_d = 1'b0;
      m_data_d  = BUBBLE_WORD;
      s_valid_d = 1'b0;
    end else if (!m_valid_q || take) begin
      if (s_valid_q) begin
        // Skid entry always drains into M first so S can never overtake M.
        m_valid_d = 1'b1;
        m_data_d  = s_data_q;
        s_valid_d = accept;
        if (accept) begin
          s_data_d = in_data;
        end
      end else if (accept) begin
        m_valid_d = 1'b1;
        m_data_d  = in_data;
      end else begin
        m_valid_d = 1'b0;
        m_data_d  = BUBBLE_WORD;
      end
    end else if (accept) begin
      s_valid_d = 1'b1;
      s_data_d  = in_data;
    end
    in_ready_d = ~s_valid_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      m_valid_q  <= 1'b0;
      m_data_q   <= BUBBLE_WORD;
      s_valid_q  <= 1'b0;
      s_data_q   <= BUBBLE_WORD;
      in_ready_q <= 1'b1;
    end else begin
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      s_valid_q  <= s_valid_d;
      s_data_q   <= s_data_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = m_valid_q;
  assign out_data  = m_data_q;
  assign occupancy = {1'b0, m_valid_q} + {1'b0, s_valid_q};

`ifdef PIPE_STAGE_SKID_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (m_valid_q && stall) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (flush && (m_valid_q || s_valid_q)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid with a FIFO scoreboard of accepted words.
module tb_pipe_stage_skid;

  logic         clk = 1'b0;
  logic         rst;
  logic         stall, flush, in_valid, out_ready;
  logic         in_ready, out_valid;
  logic [127:0] in_data, out_data;
  logic [1:0]   occupancy;
`ifdef PIPE_STAGE_SKID_PERF_EN
  logic [31:0]  stall_cnt, flush_cnt;
`endif

  logic         p_stall, p_flush, p_in_valid, p_out_ready;
  logic         p_in_ready, p_out_valid;
  logic [31:0]  p_in_data, p_out_data;
  logic [1:0]   p_occupancy;
`ifdef PIPE_STAGE_SKID_PERF_EN
  logic [31:0]  p_stall_cnt, p_flush_cnt;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [127:0] sb[$];

  always #5 clk = ~clk;

  pipe_stage_skid u_dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
`ifdef PIPE_STAGE_SKID_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  pipe_stage_skid #(.WIDTH(16), .NUM_CH(2), .BUBBLE_VAL(16'h0013)) u_par (
    .clk(clk), .rst(rst), .stall(p_stall), .flush(p_flush),
    .in_valid(p_in_valid), .in_ready(p_in_ready), .in_data(p_in_data),
    .out_valid(p_out_valid), .out_ready(p_out_ready), .out_data(p_out_data),
    .occupancy(p_occupancy)
`ifdef PIPE_STAGE_SKID_PERF_EN
    , .stall_cnt(p_stall_cnt), .flush_cnt(p_flush_cnt)
`endif
  );

  function automatic logic [127:0] mk(input logic [31:0] pc);
    return {pc + 32'h3000_0000, pc + 32'h2000_0000, pc + 32'h1000_0000, pc};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: scoreboard sampled at the falling edge, inputs may change 1 after the rising edge.
  task automatic step();
    @(negedge clk);
    if (!rst || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready && !stall) begin
        if (sb.size() == 0) check("sb_unexpected_take", 128'(out_valid), 128'd0);
        else check("sb_order", out_data, sb.pop_front());
      end
      if (in_valid && in_ready) sb.push_back(in_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 10 && sb.size() != 0; i++) step();
    check(tag, 128'(sb.size()), 128'd0);
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_data = {16{8'hA5}};
    p_stall = 1'b0; p_flush = 1'b0; p_in_valid = 1'b0; p_out_ready = 1'b1; p_in_data = '0;

    // Reset with input offered
    step(); step();
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_out_data",  out_data, 128'd0);
    check("rst_in_ready",  128'(in_ready), 128'd1);
    check("rst_occupancy", 128'(occupancy), 128'd0);
    check("rst_par_data",  128'(p_out_data), 128'h0013_0013);

    // Streaming, one-cycle latency, occupancy 1 throughout
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = mk(32'h100 + 32'(4 * i));
      step();
      check("stream_data", out_data, mk(32'h100 + 32'(4 * i)));
      check("stream_occ",  128'(occupancy), 128'd1);
      check("stream_rdy",  128'(in_ready), 128'd1);
    end
    in_valid = 1'b0;
    step();
    check("stream_empty_valid", 128'(out_valid), 128'd0);
    check("stream_empty_data",  out_data, 128'd0);
    drain("stream_drain");

    // Skid fill under stall
    in_valid = 1'b1; in_data = mk(32'h200);
    step();
    stall = 1'b1; in_data = mk(32'h204);
    step();
    check("skid_occ2",   128'(occupancy), 128'd2);
    check("skid_rdy0",   128'(in_ready), 128'd0);
    check("skid_hold_m", out_data, mk(32'h200));
    in_data = mk(32'h208);
    step();
    check("skid_occ2_held", 128'(occupancy), 128'd2);
    check("skid_stable",    out_data, mk(32'h200));
    stall = 1'b0;
    step();
    check("skid_rel_data", out_data, mk(32'h204));
    check("skid_rel_rdy",  128'(in_ready), 128'd1);
    step();
    check("skid_last_data", out_data, mk(32'h208));
    in_valid = 1'b0;
    drain("skid_drain");
    check("skid_empty", 128'(out_valid), 128'd0);

    // Flush at occupancy 2 with a word offered in the same cycle
    out_ready = 1'b0; in_valid = 1'b1; in_data = mk(32'h2A0);
    step();
    in_data = mk(32'h2A4);
    step();
    check("flush_pre_occ", 128'(occupancy), 128'd2);
    flush = 1'b1; stall = 1'b1; in_data = mk(32'h300);
    step();
    flush = 1'b0; stall = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("flush_valid", 128'(out_valid), 128'd0);
    check("flush_data",  out_data, 128'd0);
    check("flush_occ",   128'(occupancy), 128'd0);
    check("flush_rdy",   128'(in_ready), 128'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("flush_no_leak", 128'(out_valid), 128'd0);
    end

    // Mid-operation reset discards held entries
    out_ready = 1'b0; in_valid = 1'b1; in_data = mk(32'h400);
    step();
    in_data = mk(32'h404);
    step();
    in_valid = 1'b0; rst = 1'b0;
    step();
    rst = 1'b1; out_ready = 1'b1;
    step();
    check("midrst_valid", 128'(out_valid), 128'd0);
    check("midrst_occ",   128'(occupancy), 128'd0);

`ifdef PIPE_STAGE_SKID_PERF_EN
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("perf_rst_stall", 128'(stall_cnt), 128'd0);
    in_valid = 1'b1; in_data = mk(32'h500);
    step();
    in_valid = 1'b0; stall = 1'b1;
    for (int i = 0; i < 5; i++) step();
    stall = 1'b0; out_ready = 1'b0; flush = 1'b1;
    step();
    check("perf_stall_cnt", 128'(stall_cnt), 128'd5);
    check("perf_flush_cnt", 128'(flush_cnt), 128'd1);
    step();
    flush = 1'b0; out_ready = 1'b1;
    check("perf_flush_empty", 128'(flush_cnt), 128'd1);
`endif

    // Parametrised instance passes data unchanged
    p_in_valid = 1'b1; p_in_data = {16'h1234, 16'hBEEF};
    step();
    p_in_valid = 1'b0;
    check("par_data",  128'(p_out_data), 128'h1234_BEEF);
    check("par_valid", 128'(p_out_valid), 128'd1);
    step();
    check("par_idle",  128'(p_out_data), 128'h0013_0013);

    check("sb_final_empty", 128'(sb.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
